hold_path_stim_checker: RTL

//  Drives a pseudo-random vector stream into the two-flop launch/capture test net (IN1 -> FF -> NAND(IN2) -> FF -> OUT).

---
 rtl/hold_path_stim_checker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hold_path_stim_checker.sv
// Stimulus generator and golden-model checker for the two-flop launch/capture net
// (IN1 -> FF -> NAND(IN2) -> FF -> OUT); drives LFSR vectors and counts OUT mismatches.
module hold_path_stim_checker #(
  parameter int unsigned VEC_W = 16,
  parameter int unsigned ERR_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vec,
  output logic             IN1_drv,
  output logic             IN2_drv,
  input  logic             OUT_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_fail_idx,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting towards bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q;
  logic [VEC_W-1:0]   num_vec_q;
  logic [VEC_W-1:0]   vec_idx_q;
  logic               in1_q, in2_q;
  logic               m_in1_q, m_vld_q;
  logic [VEC_W-1:0]   m_idx_q;
  logic               exp_q, exp_vld_q;
  logic [VEC_W-1:0]   exp_idx_q;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   ffi_q, ffi_d;
  logic               pass_q;
  logic               accept;
  logic               last_vec;
  logic               mismatch;

  assign accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start
                    && (num_vec != '0);
  assign last_vec = (vec_idx_q == (num_vec_q - VEC_W'(1)));
  assign mismatch = exp_vld_q && (OUT_obs != exp_q);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last_vec) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  if (accept) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // The error counter never returns to zero within a run, so zero marks "no failure yet".
  always_comb begin
    err_d = err_q;
    ffi_d = ffi_q;
    if (accept) begin
      err_d = '0;
      ffi_d = '0;
    end else if (mismatch) begin
      if (err_q == '0) ffi_d = exp_idx_q;
      if (err_q != '1) err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lfsr_q    <= SEED_EFF;
      num_vec_q <= '0;
      vec_idx_q <= '0;
      in1_q     <= 1'b0;
      in2_q     <= 1'b0;
      m_in1_q   <= 1'b0;
      m_vld_q   <= 1'b0;
      m_idx_q   <= '0;
      exp_q     <= 1'b0;
      exp_vld_q <= 1'b0;
      exp_idx_q <= '0;
      err_q     <= '0;
      ffi_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      // Golden net: stage 1 mirrors FF1, stage 2 forms the value FF2 must present next cycle.
      m_in1_q   <= in1_q;
      m_vld_q   <= (state_q == S_RUN);
      m_idx_q   <= vec_idx_q;
      exp_q     <= ~(m_in1_q & in2_q);
      exp_vld_q <= m_vld_q && (state_q == S_RUN);
      exp_idx_q <= m_idx_q;
      err_q     <= err_d;
      ffi_q     <= ffi_d;
      if (accept) begin
        lfsr_q    <= lfsr_step(SEED_EFF);
        in1_q     <= SEED_EFF[0];
        in2_q     <= SEED_EFF[1];
        num_vec_q <= num_vec;
        vec_idx_q <= '0;
        pass_q    <= 1'b0;
      end else if (state_q == S_RUN) begin
        if (last_vec) begin
          in1_q <= 1'b0;
          in2_q <= 1'b0;
        end else begin
          in1_q     <= lfsr_q[0];
          in2_q     <= lfsr_q[1];
          lfsr_q    <= lfsr_step(lfsr_q);
          vec_idx_q <= vec_idx_q + VEC_W'(1);
        end
      end
      if (state_q == S_FLUSH) pass_q <= (err_d == '0);
    end
  end

  assign IN1_drv        = in1_q;
  assign IN2_drv        = in2_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_idx = ffi_q;

endmodule
